// File: rtl/regbus2axi4lite.sv
// regbus to AXI4-Lite master bridge.
// Turns a single-beat regbus register access into one AXI4-Lite transaction,
// one access in flight at a time, with a per-state timeout that aborts a
// transaction whose slave never answers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight, accepts addr_valid
// WR_REQ  | AW and W offered; each channel drops after its own handshake
// WR_RESP | both write channels done, waiting for B with m_bready=1
// RD_REQ  | AR offered, waiting for m_arready
// RD_RESP | AR done, waiting for R with m_rready=1
module regbus2axi4lite #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ERR_RDATA      = 'hDEADBEEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                addr_valid,
    input  logic                reg_write,
    input  logic [ADDR_W-1:0]   reg_addr,
    input  logic [DATA_W-1:0]   reg_wdata,
    output logic [DATA_W-1:0]   reg_rdata,
    output logic                reg_ready,
    output logic                reg_err,
    output logic                reg_busy,
    output logic                drop_err,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);

    // Counter only has to reach TIMEOUT_CYCLES-1; a disabled timeout keeps one bit.
    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               timeout_hit;
    logic               abort;
    logic               awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic [ADDR_W-1:0]  awaddr_nxt, araddr_nxt;
    logic [DATA_W-1:0]  wdata_nxt, rdata_nxt;
    logic               ready_nxt, err_nxt;

    // Protection is always unprivileged/secure/data; every write is full width.
    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;
    assign m_wstrb  = '1;

    // Last busy cycle of the current state when the timeout is enabled.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TO_LAST));

    // Next state and next value of every registered output.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        awvalid_nxt = m_awvalid;
        wvalid_nxt  = m_wvalid;
        bready_nxt  = m_bready;
        arvalid_nxt = m_arvalid;
        rready_nxt  = m_rready;
        awaddr_nxt  = m_awaddr;
        araddr_nxt  = m_araddr;
        wdata_nxt   = m_wdata;
        rdata_nxt   = reg_rdata;
        ready_nxt   = 1'b0;
        err_nxt     = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (addr_valid) begin
                    if (reg_write) begin
                        state_nxt   = WR_REQ;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        awaddr_nxt  = reg_addr;
                        wdata_nxt   = reg_wdata;
                    end else begin
                        state_nxt   = RD_REQ;
                        arvalid_nxt = 1'b1;
                        araddr_nxt  = reg_addr;
                    end
                end
            end
            WR_REQ: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (m_awvalid && m_awready) awvalid_nxt = 1'b0;
                if (m_wvalid && m_wready)   wvalid_nxt  = 1'b0;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    state_nxt  = WR_RESP;
                    bready_nxt = 1'b1;
                    cnt_nxt    = '0;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            WR_RESP: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (m_bvalid && m_bready) begin
                    state_nxt  = IDLE;
                    bready_nxt = 1'b0;
                    ready_nxt  = 1'b1;
                    err_nxt    = (m_bresp != 2'b00);
                    rdata_nxt  = '0;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RD_REQ: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (m_arvalid && m_arready) begin
                    state_nxt   = RD_RESP;
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    cnt_nxt     = '0;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RD_RESP: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (m_rvalid && m_rready) begin
                    state_nxt  = IDLE;
                    rready_nxt = 1'b0;
                    ready_nxt  = 1'b1;
                    err_nxt    = (m_rresp != 2'b00);
                    rdata_nxt  = (m_rresp == 2'b00) ? m_rdata : ERR_RDATA;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Abort withdraws every handshake signal so a late response lands nowhere.
        if (abort) begin
            state_nxt   = IDLE;
            awvalid_nxt = 1'b0;
            wvalid_nxt  = 1'b0;
            bready_nxt  = 1'b0;
            arvalid_nxt = 1'b0;
            rready_nxt  = 1'b0;
            cnt_nxt     = '0;
            ready_nxt   = 1'b1;
            err_nxt     = 1'b1;
            rdata_nxt   = ERR_RDATA;
        end
    end

    // State, timer and all outputs registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            m_awaddr  <= '0;
            m_araddr  <= '0;
            m_wdata   <= '0;
            reg_rdata <= '0;
            reg_ready <= 1'b0;
            reg_err   <= 1'b0;
            reg_busy  <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            m_awvalid <= awvalid_nxt;
            m_wvalid  <= wvalid_nxt;
            m_bready  <= bready_nxt;
            m_arvalid <= arvalid_nxt;
            m_rready  <= rready_nxt;
            m_awaddr  <= awaddr_nxt;
            m_araddr  <= araddr_nxt;
            m_wdata   <= wdata_nxt;
            reg_rdata <= rdata_nxt;
            reg_ready <= ready_nxt;
            reg_err   <= err_nxt;
            reg_busy  <= (state_nxt != IDLE);
            drop_err  <= addr_valid && (state != IDLE);
        end
    end

endmodule

// File: tb/tb_regbus2axi4lite.sv
// Testbench for regbus2axi4lite: randomized and directed accesses against a
// latency/result model derived from the bridge's handshake rules.
module tb_regbus2axi4lite;

    localparam int TO = 16;
    localparam logic [31:0] DEAD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        addr_valid, reg_write;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic        reg_ready, reg_err, reg_busy, drop_err;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    int n_chk = 0;
    int n_err = 0;

    logic        chain_wr;
    logic [31:0] chain_addr, chain_wdata;

    regbus2axi4lite #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEADBEEF)
    ) dut (
        .clk(clk), .rst(rst),
        .addr_valid(addr_valid), .reg_write(reg_write), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ready(reg_ready),
        .reg_err(reg_err), .reg_busy(reg_busy), .drop_err(drop_err),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slave();
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = '0;
    endtask

    // One regbus access with a scripted slave. Delays >= TO mean "never in time".
    // Called and returns 1 time unit after a rising edge.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int aw_d, input int w_d, input int b_d,
                          input int ar_d, input int r_d,
                          input logic [1:0] resp, input logic [31:0] rdat,
                          input bit drop, input bit chain, input bit pre);
        int exp_k, d, exp_aw, exp_w, exp_b, exp_ar, exp_r;
        bit to, exp_err;
        logic [31:0] exp_rdata;
        int k = 0, ready_k = 0, rdy_cnt = 0, drop_cnt = 0, drop_k = 0, pv = 0;
        int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
        int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
        int aw_k = 0, w_k = 0, ar_k = 0;
        bit got_err = 0, got_busy = 1, busy1 = 0;
        logic [31:0] got_rdata = '0, last_rdata = '0;
        bit p_awv = 0, p_aws = 0, p_wv = 0, p_ws = 0, p_arv = 0, p_ars = 0;
        logic [31:0] p_awa = '0, p_wd = '0, p_ara = '0;

        // Reference model: completion cycle counted from the request cycle.
        exp_aw = 0; exp_w = 0; exp_b = 0; exp_ar = 0; exp_r = 0;
        if (wr) begin
            d = (aw_d > w_d) ? aw_d : w_d;
            exp_aw = (aw_d < TO) ? 1 : 0;
            exp_w  = (w_d < TO) ? 1 : 0;
            if (d >= TO)        begin exp_k = TO + 1;         to = 1; end
            else if (b_d >= TO) begin exp_k = d + 2 + TO;     to = 1; end
            else                begin exp_k = d + 3 + b_d;    to = 0; exp_b = 1; end
            exp_err   = to || (resp != 2'b00);
            exp_rdata = to ? DEAD : 32'h0;
        end else begin
            exp_ar = (ar_d < TO) ? 1 : 0;
            if (ar_d >= TO)     begin exp_k = TO + 1;         to = 1; end
            else if (r_d >= TO) begin exp_k = ar_d + 2 + TO;  to = 1; end
            else                begin exp_k = ar_d + 3 + r_d; to = 0; exp_r = 1; end
            exp_err   = to || (resp != 2'b00);
            exp_rdata = exp_err ? DEAD : rdat;
        end

        if (!pre) begin
            reg_write = wr; reg_addr = addr; reg_wdata = wdata; addr_valid = 1'b1;
        end
        while (k < 80) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                busy1 = reg_busy;
                if (drop) begin
                    reg_write = ~wr; reg_addr = addr ^ 32'hFFFF_0000; reg_wdata = ~wdata;
                    addr_valid = 1'b1;
                end else begin
                    addr_valid = 1'b0;
                end
            end else if (k == 2) begin
                addr_valid = 1'b0;
            end
            if (drop_err) begin drop_cnt++; drop_k = k; end
            // Valid must hold with stable payload until its handshake (abort excepted).
            if (p_awv && !p_aws) begin
                if (!m_awvalid && !reg_ready) pv++;
                if (m_awvalid && m_awaddr != p_awa) pv++;
            end
            if (p_wv && !p_ws) begin
                if (!m_wvalid && !reg_ready) pv++;
                if (m_wvalid && m_wdata != p_wd) pv++;
            end
            if (p_arv && !p_ars) begin
                if (!m_arvalid && !reg_ready) pv++;
                if (m_arvalid && m_araddr != p_ara) pv++;
            end
            // Scripted slave.
            m_awready = m_awvalid && (aw_cnt >= aw_d);
            if (m_awvalid) aw_cnt++;
            if (m_awvalid && m_awready) begin
                aw_hs++; aw_k = k;
                check("awaddr", 64'(m_awaddr), 64'(addr));
                check("awprot", 64'(m_awprot), 64'(0));
            end
            m_wready = m_wvalid && (w_cnt >= w_d);
            if (m_wvalid) w_cnt++;
            if (m_wvalid && m_wready) begin
                w_hs++; w_k = k;
                check("wdata", 64'(m_wdata), 64'(wdata));
                check("wstrb", 64'(m_wstrb), 64'(4'hF));
            end
            m_bresp  = resp;
            m_bvalid = (aw_hs > 0) && (w_hs > 0) && (b_hs == 0) &&
                       (k >= ((aw_k > w_k) ? aw_k : w_k) + 1 + b_d);
            if (m_bvalid && m_bready) b_hs++;
            m_arready = m_arvalid && (ar_cnt >= ar_d);
            if (m_arvalid) ar_cnt++;
            if (m_arvalid && m_arready) begin
                ar_hs++; ar_k = k;
                check("araddr", 64'(m_araddr), 64'(addr));
            end
            m_rdata  = rdat;
            m_rresp  = resp;
            m_rvalid = (ar_hs > 0) && (r_hs == 0) && (k >= ar_k + 1 + r_d);
            if (m_rvalid && m_rready) r_hs++;
            p_awv = m_awvalid; p_aws = m_awvalid && m_awready; p_awa = m_awaddr;
            p_wv  = m_wvalid;  p_ws  = m_wvalid && m_wready;   p_wd  = m_wdata;
            p_arv = m_arvalid; p_ars = m_arvalid && m_arready; p_ara = m_araddr;
            last_rdata = reg_rdata;
            if (reg_ready) begin
                rdy_cnt++;
                if (ready_k == 0) begin
                    ready_k = k; got_err = reg_err; got_rdata = reg_rdata; got_busy = reg_busy;
                    if (chain) begin
                        reg_write = chain_wr; reg_addr = chain_addr; reg_wdata = chain_wdata;
                        addr_valid = 1'b1;
                        break;
                    end
                end
            end
            if (ready_k != 0 && k >= ready_k + 4) break;
        end
        clear_slave();
        if (!chain) addr_valid = 1'b0;

        check("latency", 64'(ready_k), 64'(exp_k));
        check("ready_count", 64'(rdy_cnt), 64'(1));
        check("reg_err", 64'(got_err), 64'(exp_err));
        check("reg_rdata", 64'(got_rdata), 64'(exp_rdata));
        check("busy_first", 64'(busy1), 64'(1));
        check("busy_done", 64'(got_busy), 64'(0));
        check("hs_aw", 64'(aw_hs), 64'(exp_aw));
        check("hs_w", 64'(w_hs), 64'(exp_w));
        check("hs_b", 64'(b_hs), 64'(exp_b));
        check("hs_ar", 64'(ar_hs), 64'(exp_ar));
        check("hs_r", 64'(r_hs), 64'(exp_r));
        check("protocol", 64'(pv), 64'(0));
        check("drop_count", 64'(drop_cnt), 64'(drop ? 1 : 0));
        check("drop_cycle", 64'(drop_k), 64'(drop ? 2 : 0));
        if (!chain) check("rdata_hold", 64'(last_rdata), 64'(exp_rdata));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cnt;
        logic [31:0] a, wd, rdv;
        logic [1:0]  rs;
        bit wr;

        rst = 1'b1; addr_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
        clear_slave();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(|{m_awaddr, m_awvalid, m_wdata, m_wvalid, m_bready,
                                     m_araddr, m_arvalid, m_rready, reg_rdata, reg_ready,
                                     reg_err, reg_busy, drop_err}), 64'(0));
        check("reset_busy", 64'(reg_busy), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        access(1, 32'h10, 32'hA5A5_0001, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0, 0);
        access(0, 32'h24, 32'h0, 0, 0, 0, 3, 2, 2'b00, 32'h1234_5678, 0, 0, 0);
        access(1, 32'h30, 32'h0BAD_F00D, 4, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0, 0);
        access(0, 32'h40, 32'h0, 0, 0, 0, 1, 1, 2'b10, 32'h5555_AAAA, 0, 0, 0);
        access(1, 32'h44, 32'h1111_2222, 1, 2, 1, 0, 0, 2'b11, 32'h0, 0, 0, 0);
        access(0, 32'h50, 32'h0, 0, 0, 0, 20, 0, 2'b00, 32'h7777_7777, 0, 0, 0);
        access(0, 32'h54, 32'h0, 0, 0, 0, 0, 17, 2'b00, 32'h6666_6666, 0, 0, 0);
        access(1, 32'h58, 32'hCAFE_0001, 20, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0, 0);
        access(1, 32'h5C, 32'hCAFE_0002, 0, 1, 17, 0, 0, 2'b00, 32'h0, 0, 0, 0);
        access(0, 32'h60, 32'h0, 0, 0, 0, 2, 1, 2'b00, 32'h89AB_CDEF, 1, 0, 0);
        access(1, 32'h64, 32'h3333_4444, 2, 1, 0, 0, 0, 2'b00, 32'h0, 1, 0, 0);
        // Request presented in the completion cycle of the previous access.
        chain_wr = 1'b1; chain_addr = 32'h70; chain_wdata = 32'hFEED_BEEF;
        access(0, 32'h68, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0102_0304, 0, 1, 0);
        access(1, 32'h70, 32'hFEED_BEEF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0, 1);

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = $urandom;
            wd  = $urandom;
            rdv = $urandom;
            rs  = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
            access(wr, a, wd, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                   $urandom_range(0, 4), $urandom_range(0, 3), rs, rdv,
                   ($urandom_range(0, 3) == 0), 0, 0);
        end

        // Reset in the middle of a read.
        reg_write = 1'b0; reg_addr = 32'h80; addr_valid = 1'b1;
        @(posedge clk); #1;
        addr_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_pre_arvalid", 64'(m_arvalid), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_outputs", 64'(|{m_awaddr, m_awvalid, m_wdata, m_wvalid, m_bready,
                                   m_araddr, m_arvalid, m_rready, reg_rdata, reg_ready,
                                   reg_err, reg_busy, drop_err}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h9999_0000;
        rd_cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (reg_ready || reg_busy || m_arvalid) rd_cnt++;
        end
        clear_slave();
        check("rst_no_ready", 64'(rd_cnt), 64'(0));
        access(0, 32'h84, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h4242_4242, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
